// File: rtl/addsub_arbiter_if.sv
// Purpose: request, operand and result handshake bundle between the add/sub arbiter and its users.
// Latency: none, wires only.
// Backpressure: carries the valid/ready pairs; the arbiter drives a_ready, b_ready and res_valid.
interface addsub_arbiter_if #(
  parameter int N = 4
);
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_x;
  logic [N-1:0] a_y;
  logic         a_add_n;

  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] b_x;
  logic [N-1:0] b_y;
  logic         b_add_n;

  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_s;
  logic         res_c_out;
  logic         res_ovf;
  logic         res_id;

  // Requesters and result consumer side
  modport master (
    output a_valid, a_x, a_y, a_add_n,
    output b_valid, b_x, b_y, b_add_n,
    output res_ready,
    input  a_ready, b_ready,
    input  res_valid, res_s, res_c_out, res_ovf, res_id
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_x, a_y, a_add_n,
    input  b_valid, b_x, b_y, b_add_n,
    input  res_ready,
    output a_ready, b_ready,
    output res_valid, res_s, res_c_out, res_ovf, res_id
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Purpose: round-robin share of one ripple-carry add/sub datapath between requesters A and B.
// Latency: 1 cycle from request handshake to res_valid; at most one operation in flight.
// Backpressure: result held stable while res_ready is low; no request is accepted until it is consumed.
module addsub_arbiter #(
  parameter int N = 4
) (
  input logic            clk,
  input logic            reset,
  addsub_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state;
  logic         ptr;          // 0: A has priority, 1: B has priority
  logic         res_valid_q;
  logic [N-1:0] res_s_q;
  logic         res_c_q;
  logic         res_ovf_q;
  logic         res_id_q;

  logic         grant_a;
  logic         grant_b;
  logic [N-1:0] op_x;
  logic [N-1:0] op_y;
  logic         op_add_n;
  logic [N-1:0] y_eff;
  logic [N-1:0] sum;
  logic         carry;
  logic         c_out;
  logic         ovf;

  // Grant one requester in IDLE; the loser of a tie is the one that was served last
  always_comb begin
    grant_a = (state == IDLE) & ~reset & bus.a_valid & (~ptr | ~bus.b_valid);
    grant_b = (state == IDLE) & ~reset & bus.b_valid & ( ptr | ~bus.a_valid);
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Steer the granted operands into the shared datapath
  always_comb begin
    op_x     = grant_b ? bus.b_x     : bus.a_x;
    op_y     = grant_b ? bus.b_y     : bus.a_y;
    op_add_n = grant_b ? bus.b_add_n : bus.a_add_n;
  end

  // Subtract is x + ~y + 1: invert y and inject the +1 as carry-in
  assign y_eff = op_y ^ {N{op_add_n}};

  // Ripple-carry chain, one full adder per bit
  always_comb begin
    carry = op_add_n;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = op_x[i] ^ y_eff[i] ^ carry;
      carry  = (op_x[i] & y_eff[i]) | (carry & (op_x[i] ^ y_eff[i]));
    end
    c_out = carry;
  end

  // Signed overflow: operands of equal sign producing a result of the other sign
  assign ovf = (op_x[N-1] == y_eff[N-1]) & (sum[N-1] != op_x[N-1]);

  // Arbitration state, priority pointer and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      res_valid_q <= 1'b0;
      res_s_q     <= '0;
      res_c_q     <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a | grant_b) begin
            res_s_q     <= sum;
            res_c_q     <= c_out;
            res_ovf_q   <= ovf;
            res_id_q    <= grant_b;
            ptr         <= grant_a;   // hand priority to the requester not just served
            res_valid_q <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_s     = res_s_q;
  assign bus.res_c_out = res_c_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_id    = res_id_q;

endmodule
